ppi8255: RTL
============

# ppi8255

Parametrised 8255-compatible programmable peripheral interface. It replaces the fixed-direction PIA model at 0xB0xx with a block that has:
- a writable control word and per-group port directions;
- bit set/reset of port C;
- mode 1 strobed handshaking on ports A and B, with an interrupt output.

It sits on the 1 MHz CPU bus alongside the SPI and VIA slots and drives the keyboard row, the VDG mode and the cassette/sound lines.

## Interface
- RESET_CTRL, 8'h8A — control word loaded at reset (8'h8A = Atom layout: A out, B in, C upper in, C lower out, mode 0).
- SYNC_STAGES, 2 — synchroniser depth on pc_in handshake inputs; minimum 2.
- clk  in  1  CPU clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select; each clk cycle with cs high is exactly one access.
- rnw  in  1  1 = read, 0 = write.
- addr  in  2  0 = PA, 1 = PB, 2 = PC, 3 = control.
- din  in  8  write data.
- dout  out  8  read data, combinational on addr and state.
- pa_in / pb_in / pc_in  in  8 each  pin inputs.
- pa_out / pb_out / pc_out  out  8 each  output latches, including handshake outputs.
- pa_oe / pb_oe / pc_oe  out  8 each  per-bit output enables.
- irq  out  1  intr_a | intr_b.

## Operation
- **Control write (addr 3, din[7]=1)**
  - d6:5: group A mode. 00 = mode 0, 01 = mode 1, 1x = mode 0 (mode 2 is unsupported).
  - d4: PA direction (1 = input). d3: PC[7:4] direction. d2: group B mode. d1: PB direction. d0: PC[3:0] direction.
  - Side effects: clears pa_out, pb_out and pc_out latches, INTE_A, INTE_B, and all IBF/OBF/INTR state.
- **Bit set/reset (addr 3, din[7]=0)**
  - Sets pc_out latch bit din[3:1] to din[0].
  - In mode 1 it also writes the INTE flag mapped to that bit: PC4 → INTE_A when A is input, PC6 → INTE_A when A is output, PC2 → INTE_B.
  - Does not write handshake-owned output bits.
- **Mode 0**
  - Output port: oe = 8'hFF. A read returns the output latch.
  - Input port: oe = 0. A read returns the pin directly.
  - Write to an input port updates the latch only.
- **Mode 1 pin map, group A**
  - Input: PC4 = STB_A_n (in), PC5 = IBF_A, PC3 = INTR_A.
  - Output: PC7 = OBF_A_n, PC6 = ACK_A_n (in), PC3 = INTR_A.
- **Mode 1 pin map, group B**
  - PC2 = STB_B_n / ACK_B_n (in), PC1 = IBF_B / OBF_B_n, PC0 = INTR_B.
- **Remaining pins:** PC bits not owned by a handshake follow the d3/d0 direction.
- **Mode 1 input handshake**
  - Synchronised STB falling edge: latch port pins into the input latch, set IBF.
  - STB rising edge: set INTR if IBF & INTE.
  - CPU read of the port returns the latch and clears INTR and IBF at that edge.
- **Mode 1 output handshake**
  - CPU write loads the latch, sets OBF_n = 0 and clears INTR.
  - ACK falling edge: OBF_n = 1.
  - ACK rising edge: set INTR if INTE.
- **Port C read in mode 1:** handshake positions return status (IBF, OBF_n, INTR, INTE at the STB/ACK bit position). Other bits follow mode 0 rules.
- **Control read:** returns 8'h00.

## Timing
- Reset (async assert, sync release)
  - Control = RESET_CTRL.
  - All latches, INTE, IBF and INTR = 0; OBF_n = 1; irq = 0.
  - oe values derived from RESET_CTRL.
- Writes take effect at the clk edge that ends the cs cycle; outputs change the same edge.
- Handshake input edges are detected SYNC_STAGES+1 clks after the pin transition. IBF/OBF/INTR update on that edge; irq follows combinationally.
- Simultaneous STB falling edge and CPU read of the port in the same cycle: the strobe wins. The latch updates, IBF stays 1 and INTR is cleared.
- Simultaneous ACK rising edge and CPU write: the write wins. INTR = 0, OBF_n = 0.
- Mode set during an active handshake aborts it: all flags are cleared at that edge.
- A second STB before the read overwrites the latch; IBF stays 1.
- reset_n asserted mid-handshake clears state immediately (asynchronous).

## Test plan
- Reset with default parameters → pa_oe = FF, pb_oe = 00, pc_oe = 0F, all outputs 0, irq = 0. Write PA = 5A → pa_out = 5A; read addr 0 = 5A.
- BSR writes 8'h07 then 8'h06 → pc_out[3] goes 1, then 0. Other bits unchanged.
- Control 8'hB0 (A mode 1 in), BSR PC4 set, pa_in = C3, pulse STB_A_n low 3 clks → IBF_A = 1 after 3 clks. On STB rise, INTR_A = 1 and irq = 1. Read PA = C3, then IBF_A = 0 and irq = 0.
- Control 8'hA0 (A mode 1 out), BSR PC6 set, write PA = 81 → OBF_A_n = 0. ACK_A_n low → OBF_A_n = 1. ACK rise → irq = 1. Next write clears irq.
- Control 8'h86 (B mode 1 in), BSR PC2 set, STB_B_n pulse with pb_in = 3C → PC read shows bits 2:0 = 111. Read PB = 3C → PC[1:0] = 00.
- Mid-handshake (IBF_A = 1): assert reset_n low for 1 clk → IBF_A = 0, irq = 0, control = 8'h8A immediately.

Source files
------------

// File: rtl/ppi8255.sv
// 8255-style programmable peripheral interface: mode 0 ports, port C bit set/reset,
// and mode 1 strobed handshaking on ports A and B with an interrupt output.
module ppi8255 #(
  parameter logic [7:0] RESET_CTRL  = 8'h8A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       rnw,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_oe,
  output logic [7:0] pc_oe,
  output logic       irq
);

  logic [6:0] ctrl_q, ctrl_d;
  logic [7:0] pa_lat_q, pa_lat_d, pb_lat_q, pb_lat_d, pc_lat_q, pc_lat_d;
  logic [7:0] pa_ilat_q, pa_ilat_d, pb_ilat_q, pb_ilat_d;
  logic       inte_a_q, inte_a_d, inte_b_q, inte_b_d;
  logic       ibf_a_q, ibf_a_d, ibf_b_q, ibf_b_d;
  logic       obf_a_n_q, obf_a_n_d, obf_b_n_q, obf_b_n_d;
  logic       intr_a_q, intr_a_d, intr_b_q, intr_b_d;

  // Handshake pins packed as {PC6, PC4, PC2}; idle level is high.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0] prev_q, hs_last, hs_fall, hs_rise;

  logic a_m1, a_in, cu_in, b_m1, b_in, cl_in;
  logic wr, rd, ctrl_wr, bsr_wr, wr_pa, wr_pb, wr_pc, rd_pa, rd_pb;
  logic fall_a, rise_a, fall_b, rise_b;
  logic [7:0] hs_out_mask, hs_in_mask, hs_status, inte_vec, pc_dir_out;
  logic [7:0] pa_rd, pb_rd, pc_rd;

  assign a_m1  = (ctrl_q[6:5] == 2'b01);
  assign a_in  = ctrl_q[4];
  assign cu_in = ctrl_q[3];
  assign b_m1  = ctrl_q[2];
  assign b_in  = ctrl_q[1];
  assign cl_in = ctrl_q[0];

  assign wr      = cs & ~rnw;
  assign rd      = cs & rnw;
  assign ctrl_wr = wr & (addr == 2'd3) & din[7];
  assign bsr_wr  = wr & (addr == 2'd3) & ~din[7];
  assign wr_pa   = wr & (addr == 2'd0);
  assign wr_pb   = wr & (addr == 2'd1);
  assign wr_pc   = wr & (addr == 2'd2);
  assign rd_pa   = rd & (addr == 2'd0);
  assign rd_pb   = rd & (addr == 2'd1);

  assign hs_last = sync_q[SYNC_STAGES-1];
  assign hs_fall = prev_q & ~hs_last;
  assign hs_rise = ~prev_q & hs_last;
  assign fall_a  = a_in ? hs_fall[1] : hs_fall[2];
  assign rise_a  = a_in ? hs_rise[1] : hs_rise[2];
  assign fall_b  = hs_fall[0];
  assign rise_b  = hs_rise[0];

  // Port C bits taken over by the handshakes, and what they present.
  always_comb begin
    hs_out_mask = '0;
    hs_in_mask  = '0;
    hs_status   = '0;
    inte_vec    = '0;
    if (a_m1) begin
      hs_out_mask[3] = 1'b1;
      hs_status[3]   = intr_a_q;
      if (a_in) begin
        hs_out_mask[5] = 1'b1;
        hs_status[5]   = ibf_a_q;
        hs_in_mask[4]  = 1'b1;
        inte_vec[4]    = inte_a_q;
      end else begin
        hs_out_mask[7] = 1'b1;
        hs_status[7]   = obf_a_n_q;
        hs_in_mask[6]  = 1'b1;
        inte_vec[6]    = inte_a_q;
      end
    end
    if (b_m1) begin
      hs_out_mask[1:0] = 2'b11;
      hs_status[1]     = b_in ? ibf_b_q : obf_b_n_q;
      hs_status[0]     = intr_b_q;
      hs_in_mask[2]    = 1'b1;
      inte_vec[2]      = inte_b_q;
    end
  end

  assign pc_dir_out = {{4{~cu_in}}, {4{~cl_in}}};
  assign pa_oe  = a_in ? 8'h00 : 8'hFF;
  assign pb_oe  = b_in ? 8'h00 : 8'hFF;
  assign pc_oe  = (pc_dir_out & ~hs_in_mask) | hs_out_mask;
  assign pa_out = pa_lat_q;
  assign pb_out = pb_lat_q;
  assign pc_out = (pc_lat_q & ~hs_out_mask) | hs_status;
  assign irq    = intr_a_q | intr_b_q;

  assign pa_rd = a_in ? (a_m1 ? pa_ilat_q : pa_in) : pa_lat_q;
  assign pb_rd = b_in ? (b_m1 ? pb_ilat_q : pb_in) : pb_lat_q;
  assign pc_rd = (((pc_dir_out & pc_lat_q) | (~pc_dir_out & pc_in))
                  & ~(hs_out_mask | hs_in_mask)) | hs_status | inte_vec;

  always_comb begin
    case (addr)
      2'd0:    dout = pa_rd;
      2'd1:    dout = pb_rd;
      2'd2:    dout = pc_rd;
      default: dout = 8'h00;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    pa_lat_d  = pa_lat_q;
    pb_lat_d  = pb_lat_q;
    pc_lat_d  = pc_lat_q;
    pa_ilat_d = pa_ilat_q;
    pb_ilat_d = pb_ilat_q;
    inte_a_d  = inte_a_q;
    inte_b_d  = inte_b_q;
    ibf_a_d   = ibf_a_q;
    ibf_b_d   = ibf_b_q;
    obf_a_n_d = obf_a_n_q;
    obf_b_n_d = obf_b_n_q;
    intr_a_d  = intr_a_q;
    intr_b_d  = intr_b_q;
    if (ctrl_wr) begin
      ctrl_d    = din[6:0];
      pa_lat_d  = '0;
      pb_lat_d  = '0;
      pc_lat_d  = '0;
      pa_ilat_d = '0;
      pb_ilat_d = '0;
      inte_a_d  = 1'b0;
      inte_b_d  = 1'b0;
      ibf_a_d   = 1'b0;
      ibf_b_d   = 1'b0;
      obf_a_n_d = 1'b1;
      obf_b_n_d = 1'b1;
      intr_a_d  = 1'b0;
      intr_b_d  = 1'b0;
    end else begin
      if (bsr_wr) begin
        if (!hs_out_mask[din[3:1]]) pc_lat_d[din[3:1]] = din[0];
        if (a_m1 && (din[3:1] == (a_in ? 3'd4 : 3'd6))) inte_a_d = din[0];
        if (b_m1 && (din[3:1] == 3'd2)) inte_b_d = din[0];
      end
      if (wr_pc) pc_lat_d = (din & ~hs_out_mask) | (pc_lat_q & hs_out_mask);
      if (wr_pa) pa_lat_d = din;
      if (wr_pb) pb_lat_d = din;
      // Ordering below gives strobe-over-read and write-over-ack priority.
      if (a_m1 && a_in) begin
        if (rd_pa) begin
          ibf_a_d  = 1'b0;
          intr_a_d = 1'b0;
        end
        if (fall_a) begin
          pa_ilat_d = pa_in;
          ibf_a_d   = 1'b1;
        end
        if (rise_a && ibf_a_q && inte_a_q && !rd_pa) intr_a_d = 1'b1;
      end else if (a_m1) begin
        if (fall_a) obf_a_n_d = 1'b1;
        if (rise_a && inte_a_q) intr_a_d = 1'b1;
        if (wr_pa) begin
          obf_a_n_d = 1'b0;
          intr_a_d  = 1'b0;
        end
      end
      if (b_m1 && b_in) begin
        if (rd_pb) begin
          ibf_b_d  = 1'b0;
          intr_b_d = 1'b0;
        end
        if (fall_b) begin
          pb_ilat_d = pb_in;
          ibf_b_d   = 1'b1;
        end
        if (rise_b && ibf_b_q && inte_b_q && !rd_pb) intr_b_d = 1'b1;
      end else if (b_m1) begin
        if (fall_b) obf_b_n_d = 1'b1;
        if (rise_b && inte_b_q) intr_b_d = 1'b1;
        if (wr_pb) begin
          obf_b_n_d = 1'b0;
          intr_b_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= RESET_CTRL[6:0];
      pa_lat_q  <= '0;
      pb_lat_q  <= '0;
      pc_lat_q  <= '0;
      pa_ilat_q <= '0;
      pb_ilat_q <= '0;
      inte_a_q  <= 1'b0;
      inte_b_q  <= 1'b0;
      ibf_a_q   <= 1'b0;
      ibf_b_q   <= 1'b0;
      obf_a_n_q <= 1'b1;
      obf_b_n_q <= 1'b1;
      intr_a_q  <= 1'b0;
      intr_b_q  <= 1'b0;
      sync_q    <= '1;
      prev_q    <= '1;
    end else begin
      ctrl_q    <= ctrl_d;
      pa_lat_q  <= pa_lat_d;
      pb_lat_q  <= pb_lat_d;
      pc_lat_q  <= pc_lat_d;
      pa_ilat_q <= pa_ilat_d;
      pb_ilat_q <= pb_ilat_d;
      inte_a_q  <= inte_a_d;
      inte_b_q  <= inte_b_d;
      ibf_a_q   <= ibf_a_d;
      ibf_b_q   <= ibf_b_d;
      obf_a_n_q <= obf_a_n_d;
      obf_b_n_q <= obf_b_n_d;
      intr_a_q  <= intr_a_d;
      intr_b_q  <= intr_b_d;
      sync_q[0] <= {pc_in[6], pc_in[4], pc_in[2]};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= hs_last;
    end
  end

endmodule
